// File: rtl/inst_rom_arbiter.sv
// rtl/inst_rom_arbiter.sv - two-master arbiter for the single instruction ROM read port
module inst_rom_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        own_q, own_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m0_sel, m1_sel;

  // Grants are gated by reset so nothing reaches the ROM while rst is low.
  always_comb begin
    m0_sel = 1'b0;
    m1_sel = 1'b0;
    if (rst) begin
      if (m0_req_i && m1_req_i) begin
        if (cnt_q == CntMax) m1_sel = 1'b1;
        else                 m0_sel = 1'b1;
      end else if (m0_req_i) begin
        m0_sel = 1'b1;
      end else if (m1_req_i) begin
        m1_sel = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    own_d      = {m1_sel, m0_sel};
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (m0_sel && m1_req_i) begin
      if (cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
    end else if (m1_sel || !m1_req_i) begin
      cnt_d = '0;
    end
    if (m0_sel) m0_rdata_d = rom_data_i;
    if (m1_sel) m1_rdata_d = rom_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      own_q      <= 2'b00;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      own_q      <= own_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0_gnt_o    = m0_sel;
  assign m1_gnt_o    = m1_sel;
  assign rom_ce_o    = m0_sel | m1_sel;
  assign rom_addr_o  = m1_sel ? m1_addr_i : (m0_sel ? m0_addr_i : '0);
  assign m0_rvalid_o = own_q[0];
  assign m1_rvalid_o = own_q[1];
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// tb/tb_inst_rom_arbiter.sv - self-checking bench for inst_rom_arbiter
module tb_inst_rom_arbiter;

  typedef struct {
    int          ch;
    logic [31:0] d;
  } resp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req_r;
  logic [31:0] addr_r [4];
  logic [3:0]  gnt_w;
  logic [3:0]  rv_w;
  logic [31:0] rd_w [4];
  logic        ce_a, ce_b;
  logic [31:0] rom_addr_a, rom_addr_b;
  logic [31:0] rom_data_a, rom_data_b;

  resp_t sbq[$];
  int    n_assert;
  int    n_fail;

  // Channels: 0 = a.M0, 1 = a.M1 (MAX_BURST=4); 2 = b.M0, 3 = b.M1 (MAX_BURST=0)
  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req_i(req_r[0]), .m0_addr_i(addr_r[0]), .m0_gnt_o(gnt_w[0]),
    .m0_rvalid_o(rv_w[0]), .m0_rdata_o(rd_w[0]),
    .m1_req_i(req_r[1]), .m1_addr_i(addr_r[1]), .m1_gnt_o(gnt_w[1]),
    .m1_rvalid_o(rv_w[1]), .m1_rdata_o(rd_w[1]),
    .rom_ce_o(ce_a), .rom_addr_o(rom_addr_a), .rom_data_i(rom_data_a)
  );

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req_i(req_r[2]), .m0_addr_i(addr_r[2]), .m0_gnt_o(gnt_w[2]),
    .m0_rvalid_o(rv_w[2]), .m0_rdata_o(rd_w[2]),
    .m1_req_i(req_r[3]), .m1_addr_i(addr_r[3]), .m1_gnt_o(gnt_w[3]),
    .m1_rvalid_o(rv_w[3]), .m1_rdata_o(rd_w[3]),
    .rom_ce_o(ce_b), .rom_addr_o(rom_addr_b), .rom_data_i(rom_data_b)
  );

  assign rom_data_a = rom_addr_a + 32'h100;
  assign rom_data_b = rom_addr_b + 32'h100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge: retire responses due now, then queue this cycle's grants.
  task automatic sample();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      logic ev;
      ev = (sbq.size() > 0) && (sbq[0].ch == c);
      chk($sformatf("rvalid_ch%0d", c), {31'b0, rv_w[c]}, {31'b0, ev});
      if (ev) begin
        resp_t r;
        r = sbq.pop_front();
        chk($sformatf("rdata_ch%0d", c), rd_w[c], r.d);
      end
    end
    chk("one_gnt_a", {31'b0, gnt_w[0] & gnt_w[1]}, 32'd0);
    chk("one_gnt_b", {31'b0, gnt_w[2] & gnt_w[3]}, 32'd0);
    for (int c = 0; c < 4; c++)
      if (gnt_w[c]) sbq.push_back('{c, addr_r[c] + 32'h100});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    req_r    = 4'b0011;
    addr_r[0] = 32'h0;
    addr_r[1] = 32'h200;
    addr_r[2] = 32'h0;
    addr_r[3] = 32'h0;

    // Reset held with both requests up
    repeat (3) begin
      sample();
      chk("rst_gnt0", {31'b0, gnt_w[0]}, 32'd0);
      chk("rst_gnt1", {31'b0, gnt_w[1]}, 32'd0);
      chk("rst_ce", {31'b0, ce_a}, 32'd0);
      chk("rst_addr", rom_addr_a, 32'd0);
      chk("rst_rdata0", rd_w[0], 32'd0);
      chk("rst_rdata1", rd_w[1], 32'd0);
      adv();
    end
    rst = 1'b1;
    sample();
    chk("rel_gnt0", {31'b0, gnt_w[0]}, 32'd1);
    chk("rel_gnt1", {31'b0, gnt_w[1]}, 32'd0);
    adv();

    // M0 alone, back-to-back
    req_r[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_r[0]  = 1'b1;
      addr_r[0] = 32'(i * 4);
      sample();
      chk("b2b_gnt0", {31'b0, gnt_w[0]}, 32'd1);
      chk("b2b_rom_addr", rom_addr_a, 32'(i * 4));
      adv();
    end
    req_r[0] = 1'b0;
    sample();
    chk("idle_ce", {31'b0, ce_a}, 32'd0);
    adv();

    // Continuous contention, MAX_BURST=4
    addr_r[0] = 32'h40;
    addr_r[1] = 32'h200;
    req_r[1:0] = 2'b11;
    for (int i = 0; i < 10; i++) begin
      logic exp1;
      exp1 = ((i % 5) == 4);
      sample();
      chk($sformatf("burst_gnt1_%0d", i), {31'b0, gnt_w[1]}, {31'b0, exp1});
      chk($sformatf("burst_gnt0_%0d", i), {31'b0, gnt_w[0]}, {31'b0, !exp1});
      chk($sformatf("burst_cnt_%0d", i), {29'b0, dut_a.cnt_q}, 32'(i % 5));
      adv();
    end
    req_r[1:0] = 2'b00;
    sample();
    adv();

    // M1 requests briefly during M0 traffic, then withdraws
    req_r[1:0] = 2'b11;
    sample();
    chk("wd_cnt0", {29'b0, dut_a.cnt_q}, 32'd0);
    chk("wd_gnt1_a", {31'b0, gnt_w[1]}, 32'd0);
    adv();
    sample();
    chk("wd_cnt1", {29'b0, dut_a.cnt_q}, 32'd1);
    chk("wd_gnt1_b", {31'b0, gnt_w[1]}, 32'd0);
    adv();
    req_r[1] = 1'b0;
    sample();
    chk("wd_cnt2", {29'b0, dut_a.cnt_q}, 32'd2);
    chk("wd_gnt0", {31'b0, gnt_w[0]}, 32'd1);
    adv();
    req_r[0] = 1'b0;
    sample();
    chk("wd_cnt_clr", {29'b0, dut_a.cnt_q}, 32'd0);
    adv();

    // MAX_BURST=0: M1 wins every conflict
    addr_r[2] = 32'h10;
    addr_r[3] = 32'h20;
    req_r[3:2] = 2'b11;
    repeat (3) begin
      sample();
      chk("mb0_gnt1", {31'b0, gnt_w[3]}, 32'd1);
      chk("mb0_gnt0", {31'b0, gnt_w[2]}, 32'd0);
      adv();
    end
    req_r[3] = 1'b0;
    sample();
    chk("mb0_gnt0_alone", {31'b0, gnt_w[2]}, 32'd1);
    adv();
    req_r[2] = 1'b0;
    sample();
    adv();

    // Reset pulse drops a pending M1 response
    addr_r[1] = 32'h300;
    req_r[1]  = 1'b1;
    sample();
    chk("rp_gnt1", {31'b0, gnt_w[1]}, 32'd1);
    adv();
    req_r[1] = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    sbq.delete();
    sample();
    chk("rp_rvalid1", {31'b0, rv_w[1]}, 32'd0);
    chk("rp_rdata1", rd_w[1], 32'd0);
    chk("rp_cnt", {29'b0, dut_a.cnt_q}, 32'd0);
    adv();
    sample();
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
